// File: rtl/debug_cmd_client.sv
// Requester side of the byte-wide debug command/response link: issues one
// command strobe, collects the streamed response with a timeout, returns one parsed result.
module debug_cmd_client #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [3:0]  req_len,
    output logic [7:0]  debug_cmd,
    output logic        debug_cmd_valid,
    input  logic [7:0]  debug_resp,
    input  logic        debug_resp_valid,
    output logic        busy,
    output logic        rsp_valid,
    output logic [7:0]  rsp_opcode,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_len,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic [7:0]  stray_count
);

    // state   | meaning
    // IDLE    | ready for a request; rsp_* hold the last result
    // ISSUE   | one-cycle command strobe to the responder
    // COLLECT | capturing response bytes, timeout down-counter running
    // DONE    | one-cycle result pulse
    typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, DONE} state_t;

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [3:0]        len_q, len_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        rsp_len_q, rsp_len_d;
    logic              error_q, error_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        stray_q, stray_d;
    logic [3:0]        idx_m1;

    assign idx_m1 = rsp_len_q - 4'd1;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        tmr_d       = tmr_q;
        cmd_valid_d = 1'b0;
        rsp_valid_d = 1'b0;
        opcode_d    = opcode_q;
        data_d      = data_q;
        rsp_len_d   = rsp_len_q;
        error_d     = error_q;
        timeout_d   = timeout_q;
        stray_d     = stray_q;

        if (debug_resp_valid && (state_q != COLLECT) && (stray_q != 8'hFF)) begin
            stray_d = stray_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cmd_d       = req_cmd;
                    len_d       = (req_len == 4'd0) ? 4'd1 : req_len;
                    opcode_d    = 8'h00;
                    data_d      = 32'h0;
                    rsp_len_d   = 4'd0;
                    error_d     = 1'b0;
                    timeout_d   = 1'b0;
                    cmd_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                rsp_len_d = 4'd0;
                tmr_d     = TMR_LOAD;
                state_d   = COLLECT;
            end
            COLLECT: begin
                if (debug_resp_valid) begin
                    if (rsp_len_q == 4'd0) begin
                        opcode_d = debug_resp;
                    end else if (rsp_len_q <= 4'd4) begin
                        data_d[{idx_m1[1:0], 3'b000} +: 8] = debug_resp;
                    end
                    rsp_len_d = (rsp_len_q == 4'hF) ? 4'hF : rsp_len_q + 4'd1;
                end
                // A final byte arriving on the terminal-count cycle still counts as completion.
                if (debug_resp_valid && (rsp_len_d == len_q)) begin
                    timeout_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (tmr_q == '0) begin
                    timeout_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
                error_d = (rsp_len_d != 4'd0) && ((opcode_d == 8'hFF) || (opcode_d != cmd_q));
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= 8'h00;
            len_q       <= 4'd0;
            tmr_q       <= '0;
            cmd_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            opcode_q    <= 8'h00;
            data_q      <= 32'h0;
            rsp_len_q   <= 4'd0;
            error_q     <= 1'b0;
            timeout_q   <= 1'b0;
            stray_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            tmr_q       <= tmr_d;
            cmd_valid_q <= cmd_valid_d;
            rsp_valid_q <= rsp_valid_d;
            opcode_q    <= opcode_d;
            data_q      <= data_d;
            rsp_len_q   <= rsp_len_d;
            error_q     <= error_d;
            timeout_q   <= timeout_d;
            stray_q     <= stray_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign debug_cmd       = cmd_q;
    assign debug_cmd_valid = cmd_valid_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_opcode      = opcode_q;
    assign rsp_data        = data_q;
    assign rsp_len         = rsp_len_q;
    assign rsp_error       = error_q;
    assign rsp_timeout     = timeout_q;
    assign stray_count     = stray_q;

endmodule

// File: tb/tb_debug_cmd_client.sv
// Directed bench for debug_cmd_client; inputs change and outputs are sampled on the falling edge.
module tb_debug_cmd_client;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = 8'h00;
    logic [3:0]  req_len = 4'd0;
    logic [7:0]  debug_cmd;
    logic        debug_cmd_valid;
    logic [7:0]  debug_resp = 8'h00;
    logic        debug_resp_valid = 1'b0;
    logic        busy;
    logic        rsp_valid;
    logic [7:0]  rsp_opcode;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_len;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [7:0]  stray_count;

    int compared = 0;
    int mismatched = 0;
    int cmd_pulses = 0;
    int rsp_pulses = 0;

    debug_cmd_client #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_len(req_len),
        .debug_cmd(debug_cmd), .debug_cmd_valid(debug_cmd_valid),
        .debug_resp(debug_resp), .debug_resp_valid(debug_resp_valid),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_opcode(rsp_opcode), .rsp_data(rsp_data),
        .rsp_len(rsp_len), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .stray_count(stray_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (debug_cmd_valid) cmd_pulses++;
        if (rsp_valid) rsp_pulses++;
    end

    // Issues a request; returns on the falling edge of the first COLLECT cycle.
    task automatic do_req(input logic [7:0] cmd, input logic [3:0] len);
        @(negedge clk);
        req_valid = 1'b1; req_cmd = cmd; req_len = len;
        @(negedge clk);
        req_valid = 1'b0;
        compared++;
        if (debug_cmd_valid !== 1'b1 || debug_cmd !== cmd) begin
            mismatched++;
            $display("FAIL issue_strobe: valid=%b cmd=%h, want valid=1 cmd=%h", debug_cmd_valid, debug_cmd, cmd);
        end
        @(negedge clk);
    endtask

    task automatic send_bytes(input logic [39:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            debug_resp = v[8*i +: 8];
            debug_resp_valid = 1'b1;
            @(negedge clk);
        end
        debug_resp_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cycles, output int waited);
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < max_cycles) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic check_rsp(input string name, input logic [7:0] op, input logic [31:0] data,
                             input logic [3:0] len, input logic err, input logic tmo);
        compared++;
        if (rsp_valid !== 1'b1 || rsp_opcode !== op || rsp_data !== data || rsp_len !== len ||
            rsp_error !== err || rsp_timeout !== tmo) begin
            mismatched++;
            $display("FAIL %s: v=%b op=%h data=%h len=%0d err=%b tmo=%b, want v=1 op=%h data=%h len=%0d err=%b tmo=%b",
                     name, rsp_valid, rsp_opcode, rsp_data, rsp_len, rsp_error, rsp_timeout,
                     op, data, len, err, tmo);
        end
    endtask

    task automatic test_reset();
        #1;
        compared++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || debug_cmd_valid !== 1'b0 ||
            debug_cmd !== 8'h00 || rsp_opcode !== 8'h00 || rsp_data !== 32'h0 || rsp_len !== 4'd0 ||
            rsp_error !== 1'b0 || rsp_timeout !== 1'b0 || stray_count !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_state: ready=%b busy=%b rv=%b cv=%b cmd=%h op=%h data=%h len=%0d stray=%0d, want ready=1 rest 0",
                     req_ready, busy, rsp_valid, debug_cmd_valid, debug_cmd, rsp_opcode, rsp_data, rsp_len, stray_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int c0, r0, w;
        c0 = cmd_pulses; r0 = rsp_pulses;
        do_req(8'h03, 4'd5);
        send_bytes(40'h12_34_56_78_03, 5);
        wait_rsp(4, w);
        compared++;
        if (w !== 0) begin
            mismatched++;
            $display("FAIL basic_latency: waited %0d, want 0", w);
        end
        check_rsp("basic_result", 8'h03, 32'h12345678, 4'd5, 1'b0, 1'b0);
        @(negedge clk);
        compared++;
        if (cmd_pulses - c0 !== 1 || rsp_pulses - r0 !== 1 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_pulses: cmd=%0d rsp=%0d ready=%b, want 1 1 1", cmd_pulses - c0, rsp_pulses - r0, req_ready);
        end
    endtask

    task automatic test_error();
        int w;
        do_req(8'h55, 4'd2);
        send_bytes(40'h55_FF, 2);
        wait_rsp(4, w);
        check_rsp("error_ff", 8'hFF, 32'h00000055, 4'd2, 1'b1, 1'b0);
        // Back-to-back: the next request is taken in the cycle right after DONE.
        do_req(8'h21, 4'd1);
        send_bytes(40'h22, 1);
        wait_rsp(4, w);
        check_rsp("error_mismatch_b2b", 8'h22, 32'h0, 4'd1, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        int n, w;
        do_req(8'h01, 4'd4);
        send_bytes(40'hAA_01, 2);
        wait_rsp(40, w);
        n = w + 2;
        compared++;
        if (n !== 16) begin
            mismatched++;
            $display("FAIL timeout_latency: rsp after %0d cycles, want 16", n);
        end
        check_rsp("timeout_two_bytes", 8'h01, 32'h000000AA, 4'd2, 1'b0, 1'b1);

        do_req(8'h01, 4'd4);
        wait_rsp(40, w);
        compared++;
        if (w !== 16) begin
            mismatched++;
            $display("FAIL timeout_empty_latency: rsp after %0d cycles, want 16", w);
        end
        check_rsp("timeout_empty", 8'h00, 32'h0, 4'd0, 1'b0, 1'b1);

        do_req(8'h07, 4'd1);
        repeat (15) @(negedge clk);
        send_bytes(40'h07, 1);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL edge_busy: busy=%b, want 1", busy);
        end
        check_rsp("byte_at_expiry", 8'h07, 32'h0, 4'd1, 1'b0, 1'b0);
    endtask

    task automatic test_req_during_collect();
        int c0, w;
        c0 = cmd_pulses;
        do_req(8'h10, 4'd2);
        send_bytes(40'h10, 1);
        req_valid = 1'b1; req_cmd = 8'h99; req_len = 4'd1;
        #1;
        compared++;
        if (req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL ready_in_collect: ready=%b, want 0", req_ready);
        end
        @(negedge clk);
        send_bytes(40'h22, 1);
        req_valid = 1'b0;
        wait_rsp(4, w);
        check_rsp("ignored_req_result", 8'h10, 32'h00000022, 4'd2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        compared++;
        if (cmd_pulses - c0 !== 1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL ignored_req_strobes: cmd pulses=%0d busy=%b, want 1 0", cmd_pulses - c0, busy);
        end

        do_req(8'h20, 4'd0);
        send_bytes(40'h20, 1);
        wait_rsp(4, w);
        check_rsp("len_zero", 8'h20, 32'h0, 4'd1, 1'b0, 1'b0);
    endtask

    task automatic test_stray();
        int r0;
        @(negedge clk);
        r0 = rsp_pulses;
        debug_resp = 8'h5A;
        debug_resp_valid = 1'b1;
        repeat (100) @(negedge clk);
        compared++;
        if (stray_count !== 8'd100) begin
            mismatched++;
            $display("FAIL stray_partial: count=%0d, want 100", stray_count);
        end
        repeat (200) @(negedge clk);
        debug_resp_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (stray_count !== 8'd255 || busy !== 1'b0 || req_ready !== 1'b1 || rsp_pulses !== r0) begin
            mismatched++;
            $display("FAIL stray_saturate: count=%0d busy=%b ready=%b rsp pulses=%0d, want 255 0 1 0",
                     stray_count, busy, req_ready, rsp_pulses - r0);
        end
    endtask

    task automatic test_reset_mid();
        int r0, w;
        do_req(8'h30, 4'd4);
        send_bytes(40'h11_30, 2);
        r0 = rsp_pulses;
        rst_n = 1'b0;
        #1;
        compared++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_opcode !== 8'h00 ||
            rsp_data !== 32'h0 || rsp_len !== 4'd0 || stray_count !== 8'h00 || debug_cmd !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_mid: ready=%b busy=%b rv=%b op=%h data=%h len=%0d stray=%0d cmd=%h, want ready=1 rest 0",
                     req_ready, busy, rsp_valid, rsp_opcode, rsp_data, rsp_len, stray_count, debug_cmd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        compared++;
        if (rsp_pulses !== r0) begin
            mismatched++;
            $display("FAIL reset_no_pulse: %0d rsp pulses, want 0", rsp_pulses - r0);
        end
        do_req(8'h40, 4'd2);
        send_bytes(40'h41_40, 2);
        wait_rsp(4, w);
        check_rsp("after_reset", 8'h40, 32'h00000041, 4'd2, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_timeout();
        test_req_during_collect();
        test_stray();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule

// File: doc/debug_cmd_client.md
Name: debug_cmd_client

Overview:
- Requester side of the sniffer's byte-wide debug command/response link.
- Accepts one command request from a local master, such as a UART/USB control bridge or a self-test sequencer, and drives a single-cycle command strobe to the debug responder.
- Collects the streamed response bytes, with a timeout, and returns one parsed result: echoed opcode, up to 32 bits of little-endian payload, byte count and error/timeout flags.

Parameters:
- TIMEOUT_CYCLES, 256: cycles allowed in COLLECT before the transaction is aborted with timeout (minimum 2).
- TMR_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter (derived; not overridden).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active low
- req_valid  in  1  request strobe from local master
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_cmd  in  8  command opcode to issue
- req_len  in  4  expected response length in bytes, including the echo byte; 0 is treated as 1
- debug_cmd  out  8  command byte to responder
- debug_cmd_valid  out  1  single-cycle command strobe
- debug_resp  in  8  response byte from responder
- debug_resp_valid  in  1  response byte valid
- busy  out  1  high in every state except IDLE
- rsp_valid  out  1  one-cycle result pulse
- rsp_opcode  out  8  first response byte received (0x00 if none)
- rsp_data  out  32  response bytes 1..4, byte1 in [7:0]; bytes not received read as 0
- rsp_len  out  4  number of response bytes received, saturating at 15
- rsp_error  out  1  first byte == 0xFF, or first byte != latched cmd
- rsp_timeout  out  1  COLLECT ended by timeout
- stray_count  out  8  saturating count of response bytes received outside COLLECT

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE.
  - All outputs 0 except req_ready = 1.
  - Latched cmd/len, byte counter and timer cleared.
  - Reset mid-transaction abandons it silently; no rsp_valid pulse.
- FSM states: IDLE, ISSUE, COLLECT, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch req_cmd and max(req_len, 1); clear rsp_opcode, rsp_data, rsp_len and flags; go to ISSUE.
  - req_valid while not in IDLE is ignored; it is not queued.
- ISSUE (exactly 1 cycle):
  - debug_cmd_valid = 1, debug_cmd = latched cmd.
  - Go to COLLECT; clear the byte index and the timer.
  - debug_cmd holds its value until the next ISSUE; debug_cmd_valid is 0 in all other states.
- COLLECT:
  - Each cycle with debug_resp_valid:
    - index 0 -> rsp_opcode;
    - index 1..4 -> rsp_data[8*(index-1) +: 8];
    - index >= 5: byte counted, data discarded.
    - Index and rsp_len increment; rsp_len saturates at 15.
  - Timer increments every cycle in COLLECT.
  - Exit when the received count equals the latched length -> DONE, timeout = 0.
  - Otherwise, when the timer reaches TIMEOUT_CYCLES-1 without completion -> DONE, timeout = 1.
  - Simultaneous final byte and timeout expiry: the byte is captured and the completion path wins (timeout = 0).
- DONE (1 cycle):
  - rsp_valid = 1.
  - rsp_error = (rsp_len >= 1) && (rsp_opcode == 0xFF || rsp_opcode != latched cmd).
  - rsp_timeout as determined in COLLECT.
  - Go to IDLE.
  - rsp_* fields hold until the next accepted request.
- Stray bytes:
  - debug_resp_valid in IDLE, ISSUE or DONE increments stray_count, saturating at 255.
  - Stray bytes are not stored.
  - Cleared only by reset.
- Latency: request accept -> debug_cmd_valid on the next cycle; last response byte -> rsp_valid on the next cycle.
- Back-to-back: a new request may be accepted in the cycle after DONE.

Test Plan:
- req_cmd=0x03, len=5; responder returns 03 78 56 34 12 -> one rsp_valid pulse with rsp_opcode=0x03, rsp_data=0x12345678, rsp_len=5, rsp_error=0, rsp_timeout=0; debug_cmd_valid high exactly 1 cycle.
- req_cmd=0x55, len=2; bytes FF 55 -> rsp_error=1, rsp_opcode=0xFF, rsp_data=0x00000055, rsp_len=2.
- TIMEOUT_CYCLES=16, req_cmd=0x01, len=4, only 2 bytes sent -> rsp_valid 16 cycles after COLLECT entry, rsp_timeout=1, rsp_len=2, upper rsp_data bytes 0; with 0 bytes -> rsp_opcode=0, rsp_error=0.
- Request during COLLECT (req_valid=1, different cmd) -> req_ready=0, no second debug_cmd_valid, first result unaffected; len=0 request -> completes after 1 byte.
- 300 debug_resp_valid pulses while IDLE -> stray_count=255 (saturated), no rsp_valid, FSM stays IDLE.
- rst_n low mid-COLLECT after 2 bytes -> all outputs 0, req_ready=1, no rsp_valid; the following len=2 transaction completes normally.
